// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, data, optional parity, stop.
// Drives serializer enable, bit select, TX line, busy and status pulses.
//
// Ports:
//   CLK, RST            bit clock, async active-low reset
//   P_Data, Data_Valid  byte and request from the FIFO side
//   PAR_EN, PAR_TYP     parity enable, 0 even / 1 odd
//   ser_done, ser_data  serializer last-bit flag and current bit
//   ser_en, ser_pdata   serializer shift enable and latched byte
//   TX_OUT, busy        serial line (idle high), frame in progress
//   mux_sel             00 start, 01 data, 10 parity, 11 stop/idle
//   frame_done, tmo_err final-stop pulse, watchdog abort pulse
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int TMO_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic [DATA_WIDTH-1:0] ser_pdata,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic [1:0]            mux_sel,
  output logic                  frame_done,
  output logic                  tmo_err
);

  localparam int TW =
    (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TMO_CYCLES - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;
  logic                    pen_q, pen_d;
  logic                    par_q, par_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    stop_q, stop_d;
  logic                    terr_q, terr_d;

  logic stop_last;
  logic accept;
  logic tmo_hit;

  assign stop_last = (stop_q == STOP_LAST);
  assign tmo_hit   = (tmo_q == TMO_LAST);
  // New frames are taken in IDLE or at the end
  // of the final stop cycle (back-to-back).
  assign accept = Data_Valid &&
    ((state_q == S_IDLE) ||
     ((state_q == S_STOP) && stop_last));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      pdata_q <= '0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      stop_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pdata_q <= pdata_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      stop_q  <= stop_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pdata_d = pdata_q;
    pen_d   = pen_q;
    par_d   = par_q;
    terr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_START;
      end
      S_START: state_d = S_DATA;
      S_DATA: begin
        // ser_done has priority over the watchdog
        if (ser_done) begin
          state_d = pen_q ? S_PARITY : S_STOP;
        end else if (tmo_hit) begin
          state_d = S_STOP;
          terr_d  = 1'b1;
        end
      end
      S_PARITY: state_d = S_STOP;
      S_STOP: begin
        if (stop_last) begin
          state_d = accept ? S_START : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      pdata_d = P_Data;
      pen_d   = PAR_EN;
      par_d   = (^P_Data) ^ PAR_TYP;
    end
    // Counters clear on every entry and only
    // advance while the state is held.
    tmo_d = '0;
    if ((state_q == S_DATA) &&
        (state_d == S_DATA)) begin
      tmo_d = tmo_q + TW'(1);
    end
    stop_d = 1'b0;
    if ((state_q == S_STOP) &&
        (state_d == S_STOP)) begin
      stop_d = stop_q + 1'b1;
    end
  end

  always_comb begin
    busy       = 1'b1;
    ser_en     = 1'b0;
    mux_sel    = 2'b11;
    frame_done = 1'b0;
    unique case (state_q)
      S_IDLE:   busy    = 1'b0;
      S_START:  mux_sel = 2'b00;
      S_DATA: begin
        mux_sel = 2'b01;
        ser_en  = 1'b1;
      end
      S_PARITY: mux_sel = 2'b10;
      S_STOP:   frame_done = stop_last;
      default:  busy    = 1'b0;
    endcase
  end

  always_comb begin
    TX_OUT = 1'b1;
    unique case (mux_sel)
      2'b00:   TX_OUT = 1'b0;
      2'b01:   TX_OUT = ser_data;
      2'b10:   TX_OUT = par_q;
      default: TX_OUT = 1'b1;
    endcase
  end

  assign ser_pdata = pdata_q;
  assign tmo_err   = terr_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: random frames vs a
// bit-list model, back-to-back, watchdog, reset.
module tb_uart_tx_ctrl;

  localparam int DW  = 8;
  localparam int SB  = 1;
  localparam int TMO = 16;

  logic          CLK;
  logic          RST;
  logic [DW-1:0] P_Data;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          ser_done;
  logic          ser_data;
  logic          ser_en;
  logic [DW-1:0] ser_pdata;
  logic          TX_OUT;
  logic          busy;
  logic [1:0]    mux_sel;
  logic          frame_done;
  logic          tmo_err;

  int n_chk;
  int n_err;

  logic       hang;
  logic [4:0] sidx;

  uart_tx_ctrl #(
    .DATA_WIDTH(DW),
    .STOP_BITS (SB),
    .TMO_CYCLES(TMO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_Data    (P_Data),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .ser_done  (ser_done),
    .ser_data  (ser_data),
    .ser_en    (ser_en),
    .ser_pdata (ser_pdata),
    .TX_OUT    (TX_OUT),
    .busy      (busy),
    .mux_sel   (mux_sel),
    .frame_done(frame_done),
    .tmo_err   (tmo_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // 8-bit serializer model: LSB first,
  // ser_done on the 8th enabled cycle.
  always @(posedge CLK or negedge RST) begin
    if (!RST) sidx <= '0;
    else if (ser_en) sidx <= sidx + 5'd1;
    else sidx <= '0;
  end
  assign ser_data =
    (sidx < 5'd8) ? ser_pdata[sidx[2:0]] : 1'b0;
  assign ser_done =
    ser_en && !hang && (sidx == 5'd7);

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"}, 32'(TX_OUT), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_mux"}, 32'(mux_sel), 32'd3);
    chk({tag, "_sen"}, 32'(ser_en), 32'd0);
    chk({tag, "_fd"}, 32'(frame_done), 32'd0);
    chk({tag, "_te"}, 32'(tmo_err), 32'd0);
  endtask

  // Called at a negedge in IDLE; returns at the
  // negedge of the START cycle.
  task automatic start_frame(
    input logic [7:0] b,
    input logic       pen,
    input logic       ptyp
  );
    P_Data     = b;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
  endtask

  // Entered at the negedge of the START cycle.
  task automatic expect_frame(
    input string      tag,
    input logic [7:0] b,
    input logic       pen,
    input logic       ptyp,
    input logic       tmo,
    input logic       chain,
    input logic [7:0] nb
  );
    logic q[$];
    int   dcnt;
    int   n;
    int   em;
    dcnt = tmo ? TMO : 8;
    q.push_back(1'b0);
    for (int j = 0; j < dcnt; j++)
      q.push_back(j < 8 ? b[j] : 1'b0);
    if (pen && !tmo) q.push_back((^b) ^ ptyp);
    for (int j = 0; j < SB; j++) q.push_back(1'b1);
    n = q.size();
    for (int i = 0; i < n; i++) begin
      if (i == 0) em = 0;
      else if (i <= dcnt) em = 1;
      else if (i >= n - SB) em = 3;
      else em = 2;
      chk({tag, "_tx"}, 32'(TX_OUT), 32'(q[i]));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_mux"}, 32'(mux_sel), 32'(em));
      chk({tag, "_sen"}, 32'(ser_en),
          32'(em == 1));
      chk({tag, "_fd"}, 32'(frame_done),
          32'(i == n - 1));
      chk({tag, "_te"}, 32'(tmo_err),
          32'(tmo && (i == n - SB)));
      if (i == n - 1) begin
        Data_Valid = chain;
        P_Data     = nb;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
      end else begin
        Data_Valid = chain ? 1'b1 : 1'($urandom);
        P_Data     = 8'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYP    = 1'($urandom);
      end
      @(negedge CLK);
    end
    Data_Valid = 1'b0;
    if (!chain) chk_idle({tag, "_end"});
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    hang       = 1'b0;
    RST        = 1'b0;
    P_Data     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    repeat (3) @(negedge CLK);
    chk_idle("rst");
    chk("rst_pdata", 32'(ser_pdata), 32'd0);
    RST = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      chk_idle("idle");
    end

    start_frame(8'hA5, 1'b0, 1'b0);
    expect_frame("a5", 8'hA5, 1'b0, 1'b0,
                 1'b0, 1'b0, 8'h00);

    start_frame(8'h03, 1'b1, 1'b0);
    expect_frame("p_even", 8'h03, 1'b1, 1'b0,
                 1'b0, 1'b0, 8'h00);
    start_frame(8'h03, 1'b1, 1'b1);
    expect_frame("p_odd", 8'h03, 1'b1, 1'b1,
                 1'b0, 1'b0, 8'h00);

    start_frame(8'h55, 1'b0, 1'b0);
    expect_frame("b2b_1", 8'h55, 1'b0, 1'b0,
                 1'b0, 1'b1, 8'hFF);
    expect_frame("b2b_2", 8'hFF, 1'b0, 1'b0,
                 1'b0, 1'b0, 8'h00);

    hang = 1'b1;
    start_frame(8'h3C, 1'b1, 1'b0);
    expect_frame("tmo", 8'h3C, 1'b1, 1'b0,
                 1'b1, 1'b0, 8'h00);
    hang = 1'b0;
    start_frame(8'h81, 1'b0, 1'b0);
    expect_frame("post_tmo", 8'h81, 1'b0, 1'b0,
                 1'b0, 1'b0, 8'h00);

    for (int k = 0; k < 20; k++) begin
      logic [7:0] rb;
      logic       rp;
      logic       rt;
      rb = 8'($urandom);
      rp = 1'($urandom);
      rt = 1'($urandom);
      start_frame(rb, rp, rt);
      expect_frame("rnd", rb, rp, rt,
                   1'b0, 1'b0, 8'h00);
      repeat ($urandom_range(0, 2))
        @(negedge CLK);
    end

    start_frame(8'h6B, 1'b1, 1'b0);
    repeat (5) @(negedge CLK);
    chk("mid_sen", 32'(ser_en), 32'd1);
    #2 RST = 1'b0;
    #1;
    chk_idle("arst");
    @(negedge CLK);
    RST = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      chk_idle("post_rst");
    end
    start_frame(8'h96, 1'b1, 1'b1);
    expect_frame("post_rst_f", 8'h96, 1'b1, 1'b1,
                 1'b0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
